// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_if
// Description : Start/halt handshake and sequencing outputs for run_ctrl.
//               The master side is the host/decoder, the slave side is
//               run_ctrl itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              halt_instr;
  logic              init;
  logic              pc_en;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              halt;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output start,
    output halt_instr,
    input  init,
    input  pc_en,
    input  clr_we,
    input  clr_addr,
    input  halt,
    input  instr_count
  );

  modport slave (
    input  start,
    input  halt_instr,
    output init,
    output pc_en,
    output clr_we,
    output clr_addr,
    output halt,
    output instr_count
  );
endinterface
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run-control sequencer. Holds the PC at 0 while start is high
//               (optionally sweep-clearing data memory), runs the program
//               after start drops, stops on a HALT instruction and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_START = 1
) (
  input  wire logic   CLK,
  input  wire logic   reset_n,
  run_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Where a start request lands: the clear sweep, or straight to armed.
  localparam state_t c_RESTART_ST = (CLEAR_ON_START != 0) ? ST_CLEAR : ST_ARMED;
  localparam logic [ADDR_W-1:0] c_CLR_LAST = '1;
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [CNT_W-1:0]  r_instr_count;
  logic              w_pc_en;
  logic              w_cnt_clear;

  // HALT never commits: the enable drops in the same cycle the decoder flags it.
  assign w_pc_en = (r_state == ST_RUN) && !bus.halt_instr;

  // Counter is zeroed whenever we are, or are about to be, in a load phase.
  assign w_cnt_clear = (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_ARMED);

  // State register.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; in RUN a host abort takes priority over HALT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = c_RESTART_ST;
      end
      ST_CLEAR: begin
        if (r_clr_addr == c_CLR_LAST) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!bus.start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.start)           w_state_nxt = c_RESTART_ST;
        else if (bus.halt_instr) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) w_state_nxt = c_RESTART_ST;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Clear-sweep address: steps once per CLEAR cycle, parked at 0 otherwise.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end else begin
      r_clr_addr <= '0;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_instr_count <= '0;
    end else if (w_cnt_clear) begin
      r_instr_count <= '0;
    end else if (w_pc_en && (r_instr_count != c_CNT_MAX)) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign bus.init        = (r_state == ST_CLEAR) || (r_state == ST_ARMED);
  assign bus.clr_we      = (r_state == ST_CLEAR);
  assign bus.halt        = (r_state == ST_DONE);
  assign bus.pc_en       = w_pc_en;
  assign bus.clr_addr    = r_clr_addr;
  assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire
